// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between ALU (A) and LSU alignment (B) requesters.
// Optional grant/contention statistics are enabled by defining SHIFT_ARB_STATS_EN.
module shift_arbiter #(
  parameter bit RESET_PRIO = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [31:0]          a_in,
  input  logic [4:0]           a_how_many,
  input  logic                 a_dir,
  input  logic                 a_arithmetic,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [31:0]          b_in,
  input  logic [4:0]           b_how_many,
  input  logic                 b_dir,
  input  logic                 b_arithmetic,
`ifdef SHIFT_ARB_STATS_EN
  output logic [CNT_WIDTH-1:0] a_grant_cnt,
  output logic [CNT_WIDTH-1:0] b_grant_cnt,
  output logic [CNT_WIDTH-1:0] contend_cnt,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [31:0]          resp_data
);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("shift_arbiter: CNT_WIDTH must be at least 1");
  end

  logic        last_grant;
  logic        stage_free;
  logic        grant_a, grant_b;
  logic        accept_a, accept_b, accept;
  logic [31:0] sh_in, sh_out;
  logic [4:0]  sh_amt;
  logic        sh_dir, sh_arith;

  assign stage_free = !resp_valid || resp_ready;

  // On contention the requester that did not win the last accept is favoured.
  assign grant_a = a_valid && (!b_valid || last_grant);
  assign grant_b = b_valid && (!a_valid || !last_grant);

  assign a_ready  = rst_n && grant_a && stage_free;
  assign b_ready  = rst_n && grant_b && stage_free;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;
  assign accept   = accept_a || accept_b;

  always_comb begin
    sh_in    = a_in;
    sh_amt   = a_how_many;
    sh_dir   = a_dir;
    sh_arith = a_arithmetic;
    if (grant_b) begin
      sh_in    = b_in;
      sh_amt   = b_how_many;
      sh_dir   = b_dir;
      sh_arith = b_arithmetic;
    end
  end

  always_comb begin
    sh_out = sh_in << sh_amt;
    if (sh_dir) begin
      if (sh_arith) sh_out = 32'($signed(sh_in) >>> sh_amt);
      else          sh_out = sh_in >> sh_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      last_grant <= !RESET_PRIO;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= sh_out;
      resp_id    <= accept_b;
      last_grant <= accept_b;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
      contend_cnt <= '0;
    end else begin
      if (accept_a && a_grant_cnt != '1) a_grant_cnt <= a_grant_cnt + 1'b1;
      if (accept_b && b_grant_cnt != '1) b_grant_cnt <= b_grant_cnt + 1'b1;
      if (a_valid && b_valid && stage_free && contend_cnt != '1)
        contend_cnt <= contend_cnt + 1'b1;
    end
  end
`endif

endmodule
